// File: rtl/exception_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl_seq_if
// Description : Bundle between the MEM/WB pipeline glue, CP0 and fetch on one
//               side and the registered exception controller on the other.
//               master : pipeline/CP0/fetch side (drives cause flags, status,
//                        EPC, redirect_ready; observes commit/flush/redirect)
//               slave  : exception controller
//               Signals: ext_int, timer_int, cause_ip_sw, status_*, mem_*,
//                        cp0_epc, redirect_ready (to controller);
//                        exc_* commit record, flush, redirect_valid,
//                        redirect_pc, busy (from controller).
// Revision    : 1.0 - initial release
// ============================================================================
interface exception_ctrl_seq_if #(
  parameter int HW_INT_NUM = 6
);
  logic [HW_INT_NUM-1:0] ext_int;
  logic                  timer_int;
  logic [1:0]            cause_ip_sw;
  logic [HW_INT_NUM+1:0] status_im;
  logic                  status_ie;
  logic                  status_exl;
  logic                  status_erl;
  logic                  mem_valid;
  logic [31:0]           mem_pc;
  logic [31:0]           mem_addr;
  logic                  mem_delayslot;
  logic                  mem_ri;
  logic                  mem_ov;
  logic                  mem_sys;
  logic                  mem_bp;
  logic                  mem_eret;
  logic [1:0]            mem_ld_size;
  logic [1:0]            mem_st_size;
  logic [31:0]           cp0_epc;
  logic                  redirect_ready;
  logic                  exc_commit;
  logic [4:0]            exc_code;
  logic [31:0]           exc_epc;
  logic [31:0]           exc_badvaddr;
  logic                  exc_bd;
  logic                  exc_is_eret;
  logic                  flush;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  busy;

  modport master (
    output ext_int, timer_int, cause_ip_sw, status_im, status_ie, status_exl,
           status_erl, mem_valid, mem_pc, mem_addr, mem_delayslot, mem_ri,
           mem_ov, mem_sys, mem_bp, mem_eret, mem_ld_size, mem_st_size,
           cp0_epc, redirect_ready,
    input  exc_commit, exc_code, exc_epc, exc_badvaddr, exc_bd, exc_is_eret,
           flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  ext_int, timer_int, cause_ip_sw, status_im, status_ie, status_exl,
           status_erl, mem_valid, mem_pc, mem_addr, mem_delayslot, mem_ri,
           mem_ov, mem_sys, mem_bp, mem_eret, mem_ld_size, mem_st_size,
           cp0_epc, redirect_ready,
    output exc_commit, exc_code, exc_epc, exc_badvaddr, exc_bd, exc_is_eret,
           flush, redirect_valid, redirect_pc, busy
  );
endinterface
`default_nettype wire

// File: rtl/exception_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl_seq
// Description : Registered exception/interrupt controller at the MEM/WB
//               boundary. Synchronises external interrupt lines, prioritises
//               the causes of the instruction in MEM, then sequences
//               commit -> flush -> redirect (valid/ready) toward fetch.
// Ports       : clk  - clock
//               rst  - asynchronous reset, ACTIVE LOW
//               bus  - exception_ctrl_seq_if.slave (cause inputs, status,
//                      commit record, flush, redirect handshake, busy)
// Parameters  : HW_INT_NUM (IP/IM width = HW_INT_NUM+2), SYNC_STAGES (1..3),
//               FLUSH_CYCLES (1..4), EXC_VECTOR (handler entry)
// Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl_seq #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  wire logic            clk,
  input  wire logic            rst,
  exception_ctrl_seq_if.slave  bus
);

  localparam int unsigned c_IP_W  = HW_INT_NUM + 2;
  localparam int unsigned c_CNT_W = 3;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [4:0] c_EXC_INT  = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_ADES = 5'd5;
  localparam logic [4:0] c_EXC_SYS  = 5'd8;
  localparam logic [4:0] c_EXC_BP   = 5'd9;
  localparam logic [4:0] c_EXC_RI   = 5'd10;
  localparam logic [4:0] c_EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_commit, w_commit_nxt;
  logic               w_load;

  // --------------------------------------------------------------------------
  // External interrupt synchroniser: stage 0 samples the raw pins, only the
  // last stage is ever looked at.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] r_sync;
  logic [HW_INT_NUM-1:0]                  w_ext_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= bus.ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_ext_sync = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Interrupt request: timer shares the top IP bit with the highest ext line.
  // --------------------------------------------------------------------------
  logic [c_IP_W-1:0] w_ip;
  logic              w_int_req;

  always_comb begin
    w_ip            = {w_ext_sync, bus.cause_ip_sw};
    w_ip[c_IP_W-1]  = w_ip[c_IP_W-1] | bus.timer_int;
  end

  assign w_int_req = (|(w_ip & bus.status_im)) & bus.status_ie &
                     ~bus.status_exl & ~bus.status_erl;

  // --------------------------------------------------------------------------
  // Address-error detection (fetch, load, store)
  // --------------------------------------------------------------------------
  logic w_f_adel, w_d_adel, w_ades;

  assign w_f_adel = |bus.mem_pc[1:0];
  assign w_d_adel = ((bus.mem_ld_size == 2'b11) && (|bus.mem_addr[1:0])) ||
                    ((bus.mem_ld_size == 2'b10) && bus.mem_addr[0]);
  assign w_ades   = ((bus.mem_st_size == 2'b11) && (|bus.mem_addr[1:0])) ||
                    ((bus.mem_st_size == 2'b10) && bus.mem_addr[0]);

  // --------------------------------------------------------------------------
  // Cause priority. Interrupts only attach to a real MEM instruction so the
  // EPC always points at something restartable.
  // --------------------------------------------------------------------------
  logic        w_take;
  logic [4:0]  w_code;
  logic        w_eret;
  logic [31:0] w_badvaddr;
  logic [31:0] w_epc;

  always_comb begin
    w_take     = 1'b0;
    w_code     = c_EXC_INT;
    w_eret     = 1'b0;
    w_badvaddr = 32'd0;
    if (bus.mem_valid) begin
      if (w_int_req) begin
        w_take = 1'b1;
        w_code = c_EXC_INT;
      end else if (w_f_adel) begin
        w_take     = 1'b1;
        w_code     = c_EXC_ADEL;
        w_badvaddr = bus.mem_pc;
      end else if (bus.mem_ri) begin
        w_take = 1'b1;
        w_code = c_EXC_RI;
      end else if (bus.mem_ov) begin
        w_take = 1'b1;
        w_code = c_EXC_OV;
      end else if (bus.mem_sys) begin
        w_take = 1'b1;
        w_code = c_EXC_SYS;
      end else if (bus.mem_bp) begin
        w_take = 1'b1;
        w_code = c_EXC_BP;
      end else if (w_d_adel) begin
        w_take     = 1'b1;
        w_code     = c_EXC_ADEL;
        w_badvaddr = bus.mem_addr;
      end else if (w_ades) begin
        w_take     = 1'b1;
        w_code     = c_EXC_ADES;
        w_badvaddr = bus.mem_addr;
      end else if (bus.mem_eret) begin
        w_take = 1'b1;
        w_code = c_EXC_INT;
        w_eret = 1'b1;
      end
    end
  end

  // Delay-slot instructions restart at the branch.
  assign w_epc = bus.mem_delayslot ? (bus.mem_pc - 32'd4) : bus.mem_pc;

  // --------------------------------------------------------------------------
  // Sequencer: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_commit_nxt = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt  = S_FLUSH;
          w_cnt_nxt    = c_CNT_LOAD;
          w_commit_nxt = 1'b1;
          w_load       = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_REDIRECT;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_commit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_commit <= w_commit_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Commit record and redirect target. Loaded only on a taken event so the
  // record holds until the next commit; cp0_epc is captured here so a late
  // MTC0 to EPC cannot move an ERET target that fetch is already being offered.
  // --------------------------------------------------------------------------
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic        r_is_eret;
  logic [31:0] r_redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code        <= 5'd0;
      r_epc         <= 32'd0;
      r_badvaddr    <= 32'd0;
      r_bd          <= 1'b0;
      r_is_eret     <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else if (w_load) begin
      r_code        <= w_code;
      r_epc         <= w_epc;
      r_badvaddr    <= w_badvaddr;
      r_bd          <= bus.mem_delayslot;
      r_is_eret     <= w_eret;
      r_redirect_pc <= w_eret ? bus.cp0_epc : EXC_VECTOR;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.exc_commit     = r_commit;
  assign bus.exc_code       = r_code;
  assign bus.exc_epc        = r_epc;
  assign bus.exc_badvaddr   = r_badvaddr;
  assign bus.exc_bd         = r_bd;
  assign bus.exc_is_eret    = r_is_eret;
  assign bus.flush          = (r_state == S_FLUSH);
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_exception_ctrl_seq
// Description : Self-checking bench for exception_ctrl_seq. DUT A uses the
//               default parameters, DUT B the wide/slow configuration
//               (HW_INT_NUM=8, SYNC_STAGES=3, FLUSH_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl_seq;

  localparam int          A_HW  = 6;
  localparam int          A_SS  = 2;
  localparam int          A_FC  = 1;
  localparam int          B_HW  = 8;
  localparam int          B_SS  = 3;
  localparam int          B_FC  = 3;
  localparam logic [31:0] c_VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  exception_ctrl_seq_if #(.HW_INT_NUM(A_HW)) bus_a ();
  exception_ctrl_seq_if #(.HW_INT_NUM(B_HW)) bus_b ();

  exception_ctrl_seq #(
    .HW_INT_NUM(A_HW), .SYNC_STAGES(A_SS), .FLUSH_CYCLES(A_FC), .EXC_VECTOR(c_VEC)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  exception_ctrl_seq #(
    .HW_INT_NUM(B_HW), .SYNC_STAGES(B_SS), .FLUSH_CYCLES(B_FC), .EXC_VECTOR(c_VEC)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        ds, ri, ov, sys, bp, eret;
    logic [1:0]  ld, st, sw;
    logic [7:0]  im;
    logic        ie, exl, erl, timer;
  } stim_t;

  typedef struct {
    logic        take;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bva;
    logic        bd;
    logic        eret;
  } rec_t;

  rec_t last_rec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: causes listed in priority order, first hit wins.
  function automatic rec_t ref_eval(input stim_t s, input logic [5:0] ext_sync);
    rec_t r;
    logic [7:0] ip;
    bit irq, f_adel, d_adel, ades;
    bit hit [9];
    int code_of [9];
    ip = {ext_sync, s.sw};
    if (s.timer) ip[7] = 1'b1;
    irq    = ((ip & s.im) != 0) && s.ie && !s.exl && !s.erl;
    f_adel = (s.pc % 4) != 0;
    d_adel = (s.ld == 2'd3 && (s.addr % 4) != 0) || (s.ld == 2'd2 && (s.addr % 2) != 0);
    ades   = (s.st == 2'd3 && (s.addr % 4) != 0) || (s.st == 2'd2 && (s.addr % 2) != 0);
    hit     = '{irq, f_adel, s.ri, s.ov, s.sys, s.bp, d_adel, ades, s.eret};
    code_of = '{0, 4, 10, 12, 8, 9, 4, 5, 0};
    r      = '{default: 0};
    r.epc  = s.ds ? s.pc - 32'd4 : s.pc;
    r.bd   = s.ds;
    if (s.valid) begin
      for (int i = 0; i < 9; i++) begin
        if (hit[i]) begin
          r.take = 1'b1;
          r.code = 5'(code_of[i]);
          r.eret = (i == 8);
          r.bva  = (i == 1) ? s.pc : ((i == 6 || i == 7) ? s.addr : 32'd0);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic stim_t clean_stim();
    stim_t s;
    s = '{default: 0};
    s.valid = 1'b1;
    s.pc    = 32'h0040_0000;
    return s;
  endfunction

  task automatic drive_a(input stim_t s);
    bus_a.mem_valid     = s.valid;
    bus_a.mem_pc        = s.pc;
    bus_a.mem_addr      = s.addr;
    bus_a.mem_delayslot = s.ds;
    bus_a.mem_ri        = s.ri;
    bus_a.mem_ov        = s.ov;
    bus_a.mem_sys       = s.sys;
    bus_a.mem_bp        = s.bp;
    bus_a.mem_eret      = s.eret;
    bus_a.mem_ld_size   = s.ld;
    bus_a.mem_st_size   = s.st;
    bus_a.cause_ip_sw   = s.sw;
    bus_a.status_im     = s.im;
    bus_a.status_ie     = s.ie;
    bus_a.status_exl    = s.exl;
    bus_a.status_erl    = s.erl;
    bus_a.timer_int     = s.timer;
  endtask

  // Inputs describing a taken event are already applied; walks DUT A
  // (FLUSH_CYCLES=1) through commit, one flush cycle, and a redirect held for
  // 'delay' not-ready cycles before ready is raised.
  task automatic expect_event_a(input string tag, input rec_t e,
                                input logic [31:0] rpc, input int delay);
    tick();
    chk({tag, ".commit"},   32'(bus_a.exc_commit),   32'd1);
    chk({tag, ".code"},     32'(bus_a.exc_code),     32'(e.code));
    chk({tag, ".epc"},      bus_a.exc_epc,           e.epc);
    chk({tag, ".badvaddr"}, bus_a.exc_badvaddr,      e.bva);
    chk({tag, ".bd"},       32'(bus_a.exc_bd),       32'(e.bd));
    chk({tag, ".is_eret"},  32'(bus_a.exc_is_eret),  32'(e.eret));
    chk({tag, ".flush"},    32'(bus_a.flush),        32'd1);
    chk({tag, ".busy"},     32'(bus_a.busy),         32'd1);
    // EPC moves after commit; the redirect target must not follow it.
    bus_a.cp0_epc = ~bus_a.cp0_epc;
    tick();
    chk({tag, ".rdy_valid"}, 32'(bus_a.redirect_valid), 32'd1);
    chk({tag, ".rdy_flush"}, 32'(bus_a.flush),          32'd0);
    chk({tag, ".rdy_commit"},32'(bus_a.exc_commit),     32'd0);
    chk({tag, ".rdy_pc"},    bus_a.redirect_pc,         rpc);
    for (int d = 0; d < delay; d++) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(bus_a.redirect_valid), 32'd1);
      chk({tag, ".hold_pc"},    bus_a.redirect_pc,         rpc);
      chk({tag, ".hold_commit"},32'(bus_a.exc_commit),     32'd0);
    end
    bus_a.redirect_ready = 1'b1;
    bus_a.mem_valid      = 1'b0;
    tick();
    chk({tag, ".done_valid"}, 32'(bus_a.redirect_valid), 32'd0);
    chk({tag, ".done_busy"},  32'(bus_a.busy),           32'd0);
    chk({tag, ".done_code"},  32'(bus_a.exc_code),       32'(e.code));
    bus_a.redirect_ready = 1'b0;
    last_rec = e;
  endtask

  initial begin
    stim_t s;
    rec_t  e;
    logic [31:0] epc_in;

    last_rec = '{default: 0};
    rst = 1'b0;
    drive_a(clean_stim());
    bus_a.mem_valid      = 1'b0;
    bus_a.ext_int        = '0;
    bus_a.cp0_epc        = 32'd0;
    bus_a.redirect_ready = 1'b0;
    bus_b.ext_int = '0;        bus_b.timer_int = 1'b0;   bus_b.cause_ip_sw = 2'b00;
    bus_b.status_im = '0;      bus_b.status_ie = 1'b0;   bus_b.status_exl = 1'b0;
    bus_b.status_erl = 1'b0;   bus_b.mem_valid = 1'b0;   bus_b.mem_pc = 32'h0040_0000;
    bus_b.mem_addr = 32'd0;    bus_b.mem_delayslot = 1'b0;
    bus_b.mem_ri = 1'b0;       bus_b.mem_ov = 1'b0;      bus_b.mem_sys = 1'b0;
    bus_b.mem_bp = 1'b0;       bus_b.mem_eret = 1'b0;
    bus_b.mem_ld_size = 2'b00; bus_b.mem_st_size = 2'b00;
    bus_b.cp0_epc = 32'd0;     bus_b.redirect_ready = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst.commit", 32'(bus_a.exc_commit),     32'd0);
    chk("rst.busy",   32'(bus_a.busy),           32'd0);
    chk("rst.flush",  32'(bus_a.flush),          32'd0);
    chk("rst.rvalid", 32'(bus_a.redirect_valid), 32'd0);
    chk("rst.rpc",    bus_a.redirect_pc,         32'd0);
    chk("rst.b_busy", 32'(bus_b.busy),           32'd0);
    rst = 1'b1;
    tick();

    // ---- misaligned LW in a delay slot ----
    s = clean_stim();
    s.pc = 32'hBFC0_0100; s.addr = 32'h8000_0002; s.ld = 2'b11; s.ds = 1'b1;
    drive_a(s);
    expect_event_a("lw_adel", '{take:1, code:4, epc:32'hBFC0_00FC,
                   bva:32'h8000_0002, bd:1, eret:0}, c_VEC, 0);

    // ---- external interrupt through the synchroniser ----
    s = clean_stim();
    s.im = 8'b0000_0100; s.ie = 1'b1;
    drive_a(s);
    bus_a.ext_int = 6'b000001;
    for (int i = 0; i < A_SS; i++) begin
      tick();
      chk("irq.sync_commit", 32'(bus_a.exc_commit), 32'd0);
      chk("irq.sync_busy",   32'(bus_a.busy),       32'd0);
    end
    expect_event_a("irq", '{take:1, code:0, epc:32'h0040_0000, bva:0, bd:0, eret:0},
                   c_VEC, 1);
    // Same pending line with EXL set: masked.
    s.exl = 1'b1;
    drive_a(s);
    tick();
    chk("irq_exl.commit", 32'(bus_a.exc_commit), 32'd0);
    chk("irq_exl.busy",   32'(bus_a.busy),       32'd0);
    bus_a.mem_valid = 1'b0;
    bus_a.ext_int   = '0;
    for (int i = 0; i <= A_SS; i++) tick();

    // ---- ov + sys + software interrupt ----
    s = clean_stim();
    s.pc = 32'h0040_0010; s.ov = 1'b1; s.sys = 1'b1;
    s.sw = 2'b01; s.im = 8'b0000_0001; s.ie = 1'b1;
    drive_a(s);
    expect_event_a("ov_sys_int", '{take:1, code:0, epc:32'h0040_0010, bva:0, bd:0, eret:0},
                   c_VEC, 0);
    s.im = 8'b0000_0000;
    drive_a(s);
    expect_event_a("ov_sys_masked", '{take:1, code:12, epc:32'h0040_0010, bva:0, bd:0, eret:0},
                   c_VEC, 0);

    // ---- ERET with a slow fetch ----
    s = clean_stim();
    s.pc = 32'h8000_0200; s.eret = 1'b1;
    drive_a(s);
    bus_a.cp0_epc = 32'h8000_1234;
    expect_event_a("eret", '{take:1, code:0, epc:32'h8000_0200, bva:0, bd:0, eret:1},
                   32'h8000_1234, 3);

    // ---- randomized causes against the reference ----
    for (int n = 0; n < 80; n++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.pc    = ($urandom_range(0, 7) == 0) ? ($urandom | 32'd1) : ($urandom & ~32'd3);
      s.addr  = $urandom;
      s.ds    = 1'($urandom);
      s.ri    = ($urandom_range(0, 7) == 0);
      s.ov    = ($urandom_range(0, 7) == 0);
      s.sys   = ($urandom_range(0, 7) == 0);
      s.bp    = ($urandom_range(0, 7) == 0);
      s.eret  = ($urandom_range(0, 5) == 0);
      s.ld    = 2'($urandom);
      s.st    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      s.sw    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      s.im    = 8'($urandom);
      s.ie    = 1'($urandom);
      s.exl   = ($urandom_range(0, 3) == 0);
      s.erl   = ($urandom_range(0, 5) == 0);
      s.timer = ($urandom_range(0, 5) == 0);
      epc_in  = $urandom;
      e = ref_eval(s, 6'd0);
      drive_a(s);
      bus_a.cp0_epc = epc_in;
      if (e.take) begin
        expect_event_a("rnd", e, e.eret ? epc_in : c_VEC, int'($urandom_range(0, 2)));
      end else begin
        tick();
        chk("rnd.none_commit", 32'(bus_a.exc_commit), 32'd0);
        chk("rnd.none_busy",   32'(bus_a.busy),       32'd0);
        chk("rnd.hold_code",   32'(bus_a.exc_code),   32'(last_rec.code));
        chk("rnd.hold_epc",    bus_a.exc_epc,         last_rec.epc);
      end
    end
    bus_a.mem_valid = 1'b0;
    tick();

    // ---- asynchronous reset while a redirect is offered ----
    s = clean_stim();
    s.pc = 32'hBFC0_0100; s.addr = 32'h8000_0002; s.ld = 2'b11;
    drive_a(s);
    tick();
    tick();
    chk("rst_mid.pre_valid", 32'(bus_a.redirect_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.valid", 32'(bus_a.redirect_valid), 32'd0);
    chk("rst_mid.busy",  32'(bus_a.busy),           32'd0);
    chk("rst_mid.flush", 32'(bus_a.flush),          32'd0);
    chk("rst_mid.code",  32'(bus_a.exc_code),       32'd0);
    chk("rst_mid.rpc",   bus_a.redirect_pc,         32'd0);
    bus_a.mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_mid.post_busy",  32'(bus_a.busy),       32'd0);
    chk("rst_mid.post_commit",32'(bus_a.exc_commit), 32'd0);

    // ---- wide configuration: timer on IP[9], three flush cycles ----
    bus_b.mem_valid = 1'b1;
    bus_b.status_ie = 1'b1;
    bus_b.timer_int = 1'b1;
    bus_b.status_im = 10'b01_1111_1111;
    tick();
    chk("b.masked_commit", 32'(bus_b.exc_commit), 32'd0);
    chk("b.masked_busy",   32'(bus_b.busy),       32'd0);
    bus_b.status_im = 10'b10_0000_0000;
    tick();
    chk("b.commit", 32'(bus_b.exc_commit), 32'd1);
    chk("b.code",   32'(bus_b.exc_code),   32'd0);
    chk("b.flush",  32'(bus_b.flush),      32'd1);
    bus_b.mem_valid = 1'b0;
    for (int k = 1; k < B_FC; k++) begin
      tick();
      chk("b.flush_hold",  32'(bus_b.flush),      32'd1);
      chk("b.commit_once", 32'(bus_b.exc_commit), 32'd0);
    end
    tick();
    chk("b.flush_end", 32'(bus_b.flush),          32'd0);
    chk("b.rvalid",    32'(bus_b.redirect_valid), 32'd1);
    chk("b.rpc",       bus_b.redirect_pc,         c_VEC);
    bus_b.redirect_ready = 1'b1;
    tick();
    chk("b.done_valid", 32'(bus_b.redirect_valid), 32'd0);
    chk("b.done_busy",  32'(bus_b.busy),           32'd0);
    bus_b.redirect_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exception_ctrl_seq.md
Name: exception_ctrl_seq

Overview:
Registered exception/interrupt controller at the MEM/WB boundary of the MIPS pipeline. It is the successor to the combinational exception checker. It prioritises exception causes for the instruction in MEM and synchronises parametrised external interrupt lines. It then runs a commit/flush/redirect state machine that pulses one commit record to CP0, flushes the pipeline for a configurable number of cycles, and hands the handler or EPC target to fetch over a valid/ready handshake.

Parameters:
HW_INT_NUM, 6, number of external hardware interrupt lines; IP/IM width is HW_INT_NUM+2.
SYNC_STAGES, 2, flip-flop stages on each ext_int line (legal 1..3).
FLUSH_CYCLES, 1, cycles flush stays high before redirect (legal 1..4).
EXC_VECTOR, 32'hBFC0_0380, handler entry address.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ext_int  in  HW_INT_NUM  asynchronous external interrupt lines
timer_int  in  1  CP0 count/compare interrupt, ORed into IP MSB
cause_ip_sw  in  2  Cause.IP[1:0], already forwarded from WB MTC0
status_im  in  HW_INT_NUM+2  Status.IM, forwarded
status_ie / status_exl / status_erl  in  1 each  Status bits, forwarded
mem_valid  in  1  MEM stage holds a real instruction
mem_pc  in  32  PC of MEM instruction
mem_addr  in  32  data address
mem_delayslot  in  1  instruction is in a delay slot
mem_ri / mem_ov / mem_sys / mem_bp / mem_eret  in  1 each  decoded cause flags
mem_ld_size / mem_st_size  in  2 each  00 none, 01 byte, 10 half, 11 word
cp0_epc  in  32  current EPC, used for ERET
redirect_ready  in  1  fetch accepts redirect
exc_commit  out  1  one-cycle pulse; CP0 latches record
exc_code  out  5  ExcCode (INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12)
exc_epc / exc_badvaddr  out  32  commit record
exc_bd / exc_is_eret  out  1 each  commit record
flush  out  1  kill IF..MEM
redirect_valid  out  1  redirect offered
redirect_pc  out  32  redirect target
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, sync chains 0, flush counter 0. Applies immediately mid-operation; no pending commit survives reset.
- ext_int passes through a SYNC_STAGES flop chain; ext_sync is the last stage. Only ext_sync is used.
- Interrupt: ip = {ext_sync, cause_ip_sw}, with bit HW_INT_NUM+1 ORed with timer_int. int_req = |(ip & status_im) & status_ie & ~status_exl & ~status_erl.
- Misalignment:
  - f_adel = mem_pc[1:0]!=0.
  - d_adel = (ld_size==11 & addr[1:0]!=0) | (ld_size==10 & addr[0]).
  - ades uses the same rule on st_size.
- Priority, evaluated combinationally in IDLE only when mem_valid=1: int_req > f_adel > ri > ov > sys > bp > d_adel > ades > eret. Interrupts attach only to a valid MEM instruction.
- Record:
  - epc = mem_delayslot ? mem_pc-4 : mem_pc (32-bit wrap).
  - badvaddr = mem_pc for f_adel, mem_addr for d_adel/ades, else 0.
  - bd = mem_delayslot.
  - is_eret=1 and code 0 only when eret wins.
- FSM:
  - IDLE: on a winning cause, register the record, set exc_commit=1 and flush=1 for the next cycle, load counter=FLUSH_CYCLES-1, and go to FLUSH. With no cause, stay.
  - FLUSH: exc_commit=0 after the first cycle. flush=1. Counter decrements; at 0 go to REDIRECT with flush=0.
  - REDIRECT: redirect_valid=1. redirect_pc = is_eret ? cp0_epc (sampled at commit) : EXC_VECTOR. redirect_pc is stable while valid & ~ready. When ready=1 the handshake completes that cycle; next cycle state is IDLE and redirect_valid=0.
- While busy=1 all mem_* inputs are ignored. A new exception is accepted on the first IDLE cycle after the handshake.
- exc_commit is high for exactly one cycle per taken event. Record outputs hold until the next commit.

Test Plan:
- Reset mid-REDIRECT: drop rst -> redirect_valid, busy, and flush go 0 the same cycle; after release, state is IDLE.
- LW with mem_addr=0x8000_0002, pc=0xBFC0_0100, delayslot=1 -> exc_code=4, badvaddr=0x8000_0002, epc=0xBFC0_00FC, bd=1. flush is high for FLUSH_CYCLES cycles, then redirect_pc=0xBFC0_0380.
- ext_int[0] raised with IM[2]=1, IE=1, EXL=0 -> commit with code 0 appears only after SYNC_STAGES cycles plus a valid MEM instruction. With EXL=1, no commit.
- Simultaneous ov+sys+int on one instruction -> code 0. The same instruction with int masked -> code 12.
- ERET with cp0_epc=0x8000_1234 and redirect_ready held low for 3 cycles -> redirect_valid held 3 cycles with a stable pc 0x8000_1234. The handshake completes on the 4th cycle and IDLE follows.
- Parameter sweep (HW_INT_NUM=8, FLUSH_CYCLES=3, SYNC_STAGES=3) -> timer_int maps to IP bit 9, and flush width is 3 cycles.
